// File: rtl/conv_input_loader.sv
// Packs a host word stream into input SRAM as image records, then starts the convolution engine.
// Optional LOADER_ROW_MASK_EN zeroes row-word bits at or above ncols.
module conv_input_loader #(
   parameter int unsigned          ADDR_W    = 12,
   parameter int unsigned          DATA_W    = 16,
   parameter logic [DATA_W-1:0]    TERM_WORD = 16'h00FF,
   parameter int unsigned          MIN_DIM   = 3,
   parameter int unsigned          MAX_DIM   = 16
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              host_valid,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_ready,
   output logic [ADDR_W-1:0] ldr_sram_write_address,
   output logic [DATA_W-1:0] ldr_sram_write_data,
   output logic              ldr_sram_write_enable,
   output logic              dut_run,
   input  logic              dut_busy,
   output logic              loader_done,
   output logic              err_dims,
   output logic              err_ovf
);

   localparam logic [2:0] S_NROWS   = 3'd0;
   localparam logic [2:0] S_NCOLS   = 3'd1;
   localparam logic [2:0] S_DATA    = 3'd2;
   localparam logic [2:0] S_START   = 3'd3;
   localparam logic [2:0] S_WAIT_HI = 3'd4;
   localparam logic [2:0] S_WAIT_LO = 3'd5;

   localparam logic [DATA_W-1:0] MIN_DIM_V = DATA_W'(MIN_DIM);
   localparam logic [DATA_W-1:0] MAX_DIM_V = DATA_W'(MAX_DIM);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              full_q, full_d;
   logic              wr_en_q, wr_en_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [4:0]        nrows_q, nrows_d;
   logic [4:0]        row_cnt_q, row_cnt_d;
   logic              run_q, run_d;
   logic              done_q, done_d;
   logic              err_dims_q, err_dims_d;
   logic              err_ovf_q, err_ovf_d;

   logic              accepting;
   logic              exhausted;
   logic              accept;
   logic              dim_bad;
   logic [4:0]        row_cnt_inc;
   logic [DATA_W-1:0] row_word;

`ifdef LOADER_ROW_MASK_EN
   logic [DATA_W-1:0] ncols_q, ncols_d;
   logic [DATA_W-1:0] row_mask;

   always_comb begin
      row_mask = '0;
      for (int i = 0; i < DATA_W; i++) row_mask[i] = (ncols_q > DATA_W'(i));
   end

   assign row_word = host_data & row_mask;
`else
   assign row_word = host_data;
`endif

   assign accepting = (state_q == S_NROWS) || (state_q == S_NCOLS) || (state_q == S_DATA);
   // The next accepted word would land at ptr_q + wr_en_q; block it once that passes the top.
   assign exhausted   = full_q | (wr_en_q & (ptr_q == '1));
   assign host_ready  = reset_b & accepting & ~err_ovf_q & ~exhausted;
   assign accept      = host_valid & host_ready;
   assign dim_bad     = (host_data < MIN_DIM_V) || (host_data > MAX_DIM_V);
   assign row_cnt_inc = row_cnt_q + 5'd1;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      full_d     = full_q;
      wr_en_d    = accept;
      wr_data_d  = accept ? host_data : wr_data_q;
      nrows_d    = nrows_q;
      row_cnt_d  = row_cnt_q;
      run_d      = 1'b0;
      done_d     = done_q & ~accept;
      err_dims_d = err_dims_q;
      err_ovf_d  = err_ovf_q | (accepting & host_valid & exhausted);
`ifdef LOADER_ROW_MASK_EN
      ncols_d    = ncols_q;
`endif

      if (wr_en_q) begin
         if (ptr_q == '1) full_d = 1'b1;
         else             ptr_d  = ptr_q + 1'b1;
      end

      case (state_q)
         S_NROWS: begin
            if (accept) begin
               if (host_data == TERM_WORD) begin
                  state_d = S_START;
               end else begin
                  nrows_d = host_data[4:0];
                  if (dim_bad) err_dims_d = 1'b1;
                  state_d = S_NCOLS;
               end
            end
         end
         S_NCOLS: begin
            if (accept) begin
`ifdef LOADER_ROW_MASK_EN
               ncols_d = host_data;
`endif
               if (dim_bad) err_dims_d = 1'b1;
               row_cnt_d = '0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               wr_data_d = row_word;
               row_cnt_d = row_cnt_inc;
               // 5-bit compare: nrows=0 wraps and consumes 32 rows.
               if (row_cnt_inc == nrows_q) state_d = S_NROWS;
            end
         end
         S_START: begin
            run_d   = 1'b1;
            state_d = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (dut_busy) state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (!dut_busy) begin
               done_d  = 1'b1;
               ptr_d   = '0;
               full_d  = 1'b0;
               state_d = S_NROWS;
            end
         end
         default: state_d = S_NROWS;
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q    <= S_NROWS;
         ptr_q      <= '0;
         full_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         nrows_q    <= '0;
         row_cnt_q  <= '0;
         run_q      <= 1'b0;
         done_q     <= 1'b0;
         err_dims_q <= 1'b0;
         err_ovf_q  <= 1'b0;
`ifdef LOADER_ROW_MASK_EN
         ncols_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         full_q     <= full_d;
         wr_en_q    <= wr_en_d;
         wr_data_q  <= wr_data_d;
         nrows_q    <= nrows_d;
         row_cnt_q  <= row_cnt_d;
         run_q      <= run_d;
         done_q     <= done_d;
         err_dims_q <= err_dims_d;
         err_ovf_q  <= err_ovf_d;
`ifdef LOADER_ROW_MASK_EN
         ncols_q    <= ncols_d;
`endif
      end
   end

   assign ldr_sram_write_address = ptr_q;
   assign ldr_sram_write_data    = wr_data_q;
   assign ldr_sram_write_enable  = wr_en_q;
   assign dut_run                = run_q;
   assign loader_done            = done_q;
   assign err_dims               = err_dims_q;
   assign err_ovf                = err_ovf_q;

endmodule

// File: doc/conv_input_loader.md
Name: conv_input_loader

Overview:
- Writer-side counterpart to the convolution datapath's input-SRAM reader.
- Accepts a host word stream over a valid/ready handshake and packs it into input SRAM as image records, in the layout the datapath reads: nrows, ncols, then nrows row words, repeated, ending with a terminator word.
- Once the terminator is written, it pulses dut_run, waits for the convolution engine to raise and then drop dut_busy, and reports done.

Parameters:
- ADDR_W, 12, SRAM address width.
- DATA_W, 16, SRAM/stream word width; also the maximum row width in bits.
- TERM_WORD, 16'h00FF, nrows value that marks end of the image list.
- MIN_DIM, 3, smallest legal nrows/ncols (3x3 kernel).
- MAX_DIM, 16, largest legal nrows/ncols.

Ports:
- clk  in  1  system clock.
- reset_b  in  1  asynchronous active-low reset.
- host_valid  in  1  host word valid.
- host_data  in  16  host word.
- host_ready  out  1  loader can accept a word this cycle.
- ldr_sram_write_address  out  12  input SRAM write address.
- ldr_sram_write_data  out  16  input SRAM write data.
- ldr_sram_write_enable  out  1  input SRAM write strobe.
- dut_run  out  1  one-cycle start pulse to the convolution engine.
- dut_busy  in  1  engine busy flag.
- loader_done  out  1  high from engine completion until next accepted word.
- err_dims  out  1  sticky: an illegal nrows/ncols was received.
- err_ovf  out  1  sticky: SRAM address space exhausted.

Behaviour:
- Reset values: all outputs 0. Internal write address = 0. FSM = S_NROWS.
- Handshake:
  - A word is accepted on a rising clk edge with host_valid & host_ready.
  - host_data must be held while valid & !ready.
  - host_ready is combinational from state: 1 in S_NROWS, S_NCOLS, S_DATA, unless err_ovf is set.
- Write timing:
  - Each accepted word is registered and written 1 cycle later: enable=1, data=word, address=current pointer.
  - The pointer increments after every write.
  - Back-to-back accepts produce back-to-back writes.
- FSM:
  - S_NROWS: accept a word. If it equals TERM_WORD, write it and go to S_START. Otherwise latch it as nrows and go to S_NCOLS. If nrows is outside MIN_DIM..MAX_DIM, set err_dims; the word is still written and the flow continues.
  - S_NCOLS: accept a word, latch it as ncols (same range check), clear the row counter, go to S_DATA.
  - S_DATA: accept a word and increment the row counter. When the counter reaches nrows, go to S_NROWS.
  - S_START: wait 1 cycle for the terminator write to complete, assert dut_run for exactly 1 cycle, go to S_WAIT_HI.
  - S_WAIT_HI: wait for dut_busy=1, then go to S_WAIT_LO.
  - S_WAIT_LO: wait for dut_busy=0, then set loader_done, reset the pointer to 0, go to S_NROWS.
- loader_done clears on the next accepted word.
- Illegal nrows (0 or >MAX_DIM) in S_DATA: the counter is 5 bits wide and compares against nrows[4:0]. For nrows=0, S_DATA consumes 32 words. This is required, deterministic behaviour; err_dims flags it.
- Overflow:
  - A write to address 12'hFFF that is followed by a further accept request sets err_ovf.
  - While err_ovf is set, host_ready=0 and the pointer does not wrap.
  - err_ovf and err_dims clear only on reset_b.
- dut_busy already high in S_START is ignored until S_WAIT_HI.
- reset_b asserted mid-frame: immediate return to reset values. Any partially written image is abandoned. No write strobe follows reset release.
- Simultaneous accept and pointer at 12'hFFF: the write at 12'hFFF completes; the next accept is blocked.

Optional Feature:
- Macro LOADER_ROW_MASK_EN.
- Defined: in S_DATA the written word is host_data & ((1<<ncols)-1); bits at or above ncols are forced to 0. ncols=16 passes all bits. Header and terminator words are unmasked.
- Undefined: row words are written verbatim.

Test Plan:
- Single image: stream 3,3,0x0005,0x0002,0x0007,0x00FF with valid held 1.
  - Writes addr0..5 = 3,3,5,2,7,FF, each 1 cycle after accept.
  - dut_run pulses 1 cycle.
  - Bench raises busy 2 cycles later, drops it 10 cycles later; loader_done=1 the cycle after busy falls.
- Backpressure: host_valid toggling every cycle with a 2-image stream (4x16 then 3x5).
  - No lost or duplicated writes; addresses 0..(2+4+2+3) contiguous; terminator at addr 11.
- Illegal dims: nrows=2, ncols=20.
  - err_dims=1 after the nrows accept and stays 1.
  - 2 data words consumed, then S_NROWS.
  - err_dims clears only on reset.
- Overflow: preload the pointer by streaming 4096 words of one long sequence of 16x16 images.
  - Write at 12'hFFF occurs, err_ovf=1, host_ready=0 thereafter, no write to address 0.
- Reset mid-frame: assert reset_b=0 after the 2nd data word of a 3x3 image.
  - All outputs 0 immediately.
  - After release, a new stream writes starting at addr 0.
- LOADER_ROW_MASK_EN: ncols=5, row word 0xFFFF → written 0x001F; without the macro → 0xFFFF.
